// File: rtl/shiftr_pkg.sv
// rtl/shiftr_pkg.sv - shared types and sizing helper for the sequential right shifter
package shiftr_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   // Counter must hold 0..M inclusive so a saturated count of M fits.
   function automatic int cnt_width(input int m);
      return $clog2(m + 1);
   endfunction

endpackage

// File: rtl/alu_flags.sv
// rtl/alu_flags.sv - N/Z/V flags derived from an ALU result; V is fixed 0 for this op class
module alu_flags #(
   parameter int M = 4
) (
   input  logic [M-1:0] r,
   output logic         n,
   output logic         z,
   output logic         v
);

   assign n = r[M-1];
   assign z = ~|r;
   assign v = 1'b0;

endmodule

// File: rtl/mux_2NtoN.sv
// rtl/mux_2NtoN.sv - two-way N-bit select, d1 chosen when sel is high
module mux_2NtoN #(
   parameter int M = 1
) (
   input  logic [M-1:0] d0,
   input  logic [M-1:0] d1,
   input  logic         sel,
   output logic [M-1:0] y
);

   assign y = sel ? d1 : d0;

endmodule

// File: rtl/shiftr_seq.sv
// rtl/shiftr_seq.sv - one-bit-per-clock logical/arithmetic right shifter with start/done handshake
// Optional rotate mode enabled by defining SHIFTR_ROT_EN (adds the rot input).
module shiftr_seq
   import shiftr_pkg::*;
#(
   parameter int M = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic         arith,
`ifdef SHIFTR_ROT_EN
   input  logic         rot,
`endif
   input  logic [M-1:0] A,
   input  logic [M-1:0] B,
   output logic [M-1:0] R,
   output logic         C,
   output logic         N,
   output logic         V,
   output logic         Z,
   output logic         busy,
   output logic         done
);

   localparam int         CW     = cnt_width(M);
   localparam logic [M:0] M_WIDE = (M+1)'(M);

   state_t         state, state_nxt;
   logic [M-1:0]   sreg;
   logic [CW-1:0]  cnt;
   logic [CW-1:0]  cnt_init;
   logic [CW-1:0]  cnt_sat;
   logic           fill;
   logic           fill_init;
   logic           in_bit;
   logic           c_q;

   // Shift amounts of M or more all produce the same result as exactly M.
   assign cnt_sat = ({1'b0, B} >= M_WIDE) ? CW'(M) : CW'(B);

   mux_2NtoN #(.M(1)) u_fill_mux (
      .d0  (1'b0),
      .d1  (A[M-1]),
      .sel (arith),
      .y   (fill_init)
   );

`ifdef SHIFTR_ROT_EN
   logic rot_q;

   // In rotate mode the bit leaving reg[0] re-enters at the top instead of the fill bit.
   mux_2NtoN #(.M(1)) u_in_mux (
      .d0  (fill),
      .d1  (sreg[0]),
      .sel (rot_q),
      .y   (in_bit)
   );

   assign cnt_init = rot ? CW'(B % M) : cnt_sat;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rot_q <= 1'b0;
      end else if (state == IDLE && start) begin
         rot_q <= rot;
      end
   end
`else
   assign in_bit   = fill;
   assign cnt_init = cnt_sat;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = (cnt_init == '0) ? DONE : SHIFT;
         SHIFT:   if (cnt == CW'(1)) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sreg <= '0;
         cnt  <= '0;
         fill <= 1'b0;
         c_q  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  sreg <= A;
                  fill <= fill_init;
                  cnt  <= cnt_init;
                  c_q  <= 1'b0;
               end
            end
            SHIFT: begin
               c_q  <= sreg[0];
               sreg <= {in_bit, sreg[M-1:1]};
               cnt  <= cnt - CW'(1);
            end
            default: begin
            end
         endcase
      end
   end

   assign R    = sreg;
   assign C    = c_q;
   assign busy = (state == SHIFT);
   assign done = (state == DONE);

   alu_flags #(.M(M)) u_flags (
      .r (sreg),
      .n (N),
      .z (Z),
      .v (V)
   );

endmodule

// File: tb/tb_shiftr_seq.sv
// tb/tb_shiftr_seq.sv - scoreboard bench for shiftr_seq against an arithmetic reference model
module tb_shiftr_seq;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic       arith;
   logic       rot;
   logic [3:0] A;
   logic [3:0] B;
   logic [3:0] R;
   logic       C, N, V, Z, busy, done;

   typedef struct {
      logic [3:0] r;
      logic       c;
      int         lat;
      int         c0;
   } exp_t;

   exp_t q[$];
   int   cyc = 0;
   int   nvec = 0;
   int   nerr = 0;

   shiftr_seq #(.M(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .arith (arith),
`ifdef SHIFTR_ROT_EN
      .rot   (rot),
`endif
      .A     (A),
      .B     (B),
      .R     (R),
      .C     (C),
      .N     (N),
      .V     (V),
      .Z     (Z),
      .busy  (busy),
      .done  (done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      nvec++;
      if (act != exp) begin
         nerr++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Result from shift-amount arithmetic on integers, not bit-by-bit stepping.
   function automatic exp_t model(input logic [3:0] a, input logic [3:0] b,
                                  input logic ar, input logic ro);
      exp_t e;
      int   av = int'(a);
      int   k;
      int   sv;
      if (ro) k = int'(b) % 4;
      else    k = (int'(b) > 4) ? 4 : int'(b);
      if (ro)              e.r = 4'(((av >> k) | (av << (4 - k))) & 15);
      else if (ar && a[3]) begin
         sv  = av - 16;
         e.r = 4'((sv >>> k) & 15);
      end
      else                 e.r = 4'((av >> k) & 15);
      e.c   = (k == 0) ? 1'b0 : 1'((av >> (k - 1)) & 1);
      e.lat = k;
      e.c0  = 0;
      return e;
   endfunction

   always @(negedge clk) begin
      exp_t e;
      if (rst_n && done) begin
         if (q.size() == 0) begin
            chk("unexpected_done", 1, 0);
         end else begin
            e = q.pop_front();
            chk("R", int'(R), int'(e.r));
            chk("C", int'(C), int'(e.c));
            chk("N", int'(N), int'(e.r[3]));
            chk("Z", int'(Z), (e.r == 4'd0) ? 1 : 0);
            chk("V", int'(V), 0);
            chk("latency", cyc - e.c0, e.lat);
         end
      end
   end

   task automatic issue(input logic [3:0] a, input logic [3:0] b, input logic ar,
                        input logic ro, input bit glitch);
      exp_t e;
      bit   seen = 0;
      e = model(a, b, ar, ro);
      @(negedge clk);
      A = a; B = b; arith = ar; rot = ro; start = 1'b1;
      e.c0 = cyc + 1;
      q.push_back(e);
      @(negedge clk);
      start = 1'b0;
      chk("busy_after_start", int'(busy), (e.lat > 0) ? 1 : 0);
      for (int t = 0; t < 20; t++) begin
         if (done) begin
            seen = 1;
            break;
         end
         if (glitch && t == 0) begin
            A = 4'($urandom); B = 4'($urandom); arith = 1'($urandom);
            rot = 1'($urandom); start = 1'b1;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
      end
      start = 1'b0;
      if (!seen) begin
         chk("done_timeout", 0, 1);
         if (q.size() > 0) void'(q.pop_front());
      end
      @(negedge clk);
      chk("R_hold", int'(R), int'(e.r));
      chk("C_hold", int'(C), int'(e.c));
      repeat ($urandom_range(0, 2)) @(negedge clk);
   endtask

   initial begin
      logic ro_r;
      rst_n = 1'b0; start = 1'b0; arith = 1'b0; rot = 1'b0; A = '0; B = '0;
      repeat (3) @(negedge clk);
      chk("rst_R", int'(R), 0);
      chk("rst_C", int'(C), 0);
      chk("rst_N", int'(N), 0);
      chk("rst_Z", int'(Z), 1);
      chk("rst_V", int'(V), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      rst_n = 1'b1;

      issue(4'b1011, 4'd1, 1'b0, 1'b0, 0);
      issue(4'b1000, 4'd2, 1'b1, 1'b0, 0);
      issue(4'b0110, 4'd0, 1'b0, 1'b0, 0);
      issue(4'b1001, 4'd7, 1'b0, 1'b0, 0);
      issue(4'b1001, 4'd15, 1'b1, 1'b0, 0);
      issue(4'b1111, 4'd3, 1'b0, 1'b0, 1);
`ifdef SHIFTR_ROT_EN
      issue(4'b0011, 4'd5, 1'b0, 1'b1, 0);
      issue(4'b0110, 4'd4, 1'b1, 1'b1, 0);
`endif

      for (int i = 0; i < 40; i++) begin
`ifdef SHIFTR_ROT_EN
         ro_r = 1'($urandom);
`else
         ro_r = 1'b0;
`endif
         issue(4'($urandom), 4'($urandom), 1'($urandom), ro_r, bit'($urandom_range(0, 1)));
      end

      // Reset at the second SHIFT edge abandons the operation with no done pulse.
      @(negedge clk);
      A = 4'b1111; B = 4'd3; arith = 1'b0; rot = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      chk("abort_R", int'(R), 0);
      chk("abort_busy", int'(busy), 0);
      chk("abort_Z", int'(Z), 1);
      chk("abort_C", int'(C), 0);
      chk("abort_done", int'(done), 0);
      rst_n = 1'b1;
      repeat (8) @(negedge clk);
      chk("abort_idle_busy", int'(busy), 0);

      issue(4'b1011, 4'd1, 1'b0, 1'b0, 0);
      repeat (3) @(negedge clk);
      chk("pending_results", q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete, vectors %0d", nvec);
      $fatal(1);
   end

endmodule
